mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 106 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single shared memory port, with a
// per-transaction wait timeout that completes the access with an error flag.
module mem_bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_wen,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_q;     // 1 = master 1 was served last
    logic [7:0]  wait_q;

    logic busy;
    logic sel1;
    logic timeout_hit;
    logic finish;
    logic done_ok;
    logic pick_m1;

    assign busy        = (state_q == BUSY);
    assign sel1        = grant_q[1];
    assign timeout_hit = (TIMEOUT != 8'd0) && (wait_q == (TIMEOUT - 8'd1)) && !s_ready;
    assign done_ok     = busy && s_ready;
    assign finish      = done_ok || (busy && timeout_hit);
    // Contention goes to whoever was not served last; a lone requester always wins.
    assign pick_m1     = m1_valid && (!m0_valid || !last_q);

    assign s_valid   = busy;
    assign s_wen     = busy && (sel1 ? m1_wen : m0_wen);
    assign s_addr    = busy ? (sel1 ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata   = busy ? (sel1 ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb   = busy ? (sel1 ? m1_wstrb : m0_wstrb) : 4'h0;

    assign m0_ready  = finish && grant_q[0];
    assign m0_err    = busy && timeout_hit && grant_q[0];
    assign m0_rdata  = (done_ok && grant_q[0]) ? s_rdata : 32'h0;
    assign m1_ready  = finish && grant_q[1];
    assign m1_err    = busy && timeout_hit && grant_q[1];
    assign m1_rdata  = (done_ok && grant_q[1]) ? s_rdata : 32'h0;

    assign grant     = grant_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            wait_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state_q <= BUSY;
                        grant_q <= pick_m1 ? 2'b10 : 2'b01;
                        wait_q  <= 8'd0;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= grant_q[1];
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam logic [7:0] TO = 8'd4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        m0_valid, m0_wen, m0_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_wen, m1_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_wen, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        dbg_state;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .dbg_state(dbg_state)
    );

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;
    int mem_lat, sv_cnt, spur_mode, step_n;
    int obs_q[$];
    logic        obs_err;
    logic [31:0] obs_rd;
    int          done_step;

    // reference model: one transaction in flight, owner, age, last served
    bit mdl_busy;
    int mdl_owner, mdl_age, mdl_last;
    bit n_busy;
    int n_owner, n_age, n_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_busy = 0; mdl_owner = 0; mdl_age = 0; mdl_last = 1;
        sv_cnt = 0;
    endtask

    task automatic model_check();
        bit ok, tmo, fin;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic        e_wen;
        ok  = mdl_busy && s_ready;
        tmo = mdl_busy && (TO != 8'd0) && (mdl_age == int'(TO) - 1) && !s_ready;
        fin = ok || tmo;
        e_wen   = mdl_busy ? (mdl_owner == 1 ? m1_wen   : m0_wen)   : 1'b0;
        e_addr  = mdl_busy ? (mdl_owner == 1 ? m1_addr  : m0_addr)  : 32'h0;
        e_wdata = mdl_busy ? (mdl_owner == 1 ? m1_wdata : m0_wdata) : 32'h0;
        e_strb  = mdl_busy ? (mdl_owner == 1 ? m1_wstrb : m0_wstrb) : 4'h0;
        check("s_valid", 32'(s_valid), 32'(mdl_busy));
        check("s_wen",   32'(s_wen),   32'(e_wen));
        check("s_addr",  s_addr,  e_addr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_wstrb", 32'(s_wstrb), 32'(e_strb));
        check("grant",   32'(grant), mdl_busy ? (32'd1 << mdl_owner) : 32'd0);
        check("state",   32'(dbg_state), 32'(mdl_busy));
        check("m0_ready", 32'(m0_ready), 32'(fin && mdl_owner == 0));
        check("m1_ready", 32'(m1_ready), 32'(fin && mdl_owner == 1));
        check("m0_err",   32'(m0_err),   32'(tmo && mdl_owner == 0));
        check("m1_err",   32'(m1_err),   32'(tmo && mdl_owner == 1));
        check("m0_rdata", m0_rdata, (ok && mdl_owner == 0) ? s_rdata : 32'h0);
        check("m1_rdata", m1_rdata, (ok && mdl_owner == 1) ? s_rdata : 32'h0);
        n_busy = mdl_busy; n_owner = mdl_owner; n_age = mdl_age; n_last = mdl_last;
        if (!mdl_busy) begin
            if (m0_valid || m1_valid) begin
                n_busy  = 1;
                n_age   = 0;
                n_owner = (m0_valid && m1_valid) ? (mdl_last == 0 ? 1 : 0) : (m0_valid ? 0 : 1);
            end
        end else if (fin) begin
            n_busy = 0;
            n_last = mdl_owner;
        end else begin
            n_age = mdl_age + 1;
        end
    endtask

    // driver tasks
    task automatic set_m(input int k, input logic v, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        if (k == 0) begin
            m0_valid = v; m0_wen = wen; m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb;
        end else begin
            m1_valid = v; m1_wen = wen; m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb;
        end
    endtask

    // One clock cycle: memory responder, model comparison, model advance.
    task automatic step();
        #1;
        if (s_valid) begin
            s_ready = (sv_cnt >= mem_lat);
            s_rdata = mem[s_addr[9:2]];
        end else begin
            s_ready = (spur_mode == 1) ? 1'b1 : (spur_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            s_rdata = $urandom;
        end
        #1;
        model_check();
        if (s_valid && s_ready && s_wen) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) mem[s_addr[9:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
        end
        if (m0_ready) begin obs_q.push_back(0); obs_err = m0_err; obs_rd = m0_rdata; done_step = step_n; end
        if (m1_ready) begin obs_q.push_back(1); obs_err = m1_err; obs_rd = m1_rdata; done_step = step_n; end
        if (s_valid && !s_ready && !(m0_ready || m1_ready)) sv_cnt++;
        else sv_cnt = 0;
        @(posedge clk);
        mdl_busy = n_busy; mdl_owner = n_owner; mdl_age = n_age; mdl_last = n_last;
        step_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready = 1'b0;
        #1;
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_ready",   32'({m0_ready, m1_ready, m0_err, m1_err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mdl_reset();
        obs_q.delete();
    endtask

    initial begin
        int start;
        reset = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready = 0; s_rdata = 0;
        step_n = 0; spur_mode = 0; mem_lat = 0;
        obs_err = 0; obs_rd = 0; done_step = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mdl_reset();
        do_reset();

        // m0 write, memory answers one cycle after s_valid
        mem_lat = 1;
        set_m(0, 1, 1, 32'h0, 32'h14, 4'hF);
        step();
        m0_valid = 0;
        repeat (3) step();
        check("wr_mem0", mem[0], 32'h14);
        check("wr_count", obs_q.size(), 1);
        check("wr_err", 32'(obs_err), 32'd0);

        // simultaneous requests alternate starting with m0
        do_reset();
        mem_lat = 0;
        set_m(0, 1, 0, 32'h10, 0, 0);
        set_m(1, 1, 0, 32'h20, 0, 0);
        repeat (8) step();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        check("rr_count", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check($sformatf("rr_order%0d", i), obs_q[i], i % 2);

        // m1 read holds grant while m0 requests mid-transaction
        obs_q.delete();
        mem[1] = 32'hFF;
        mem_lat = 2;
        set_m(1, 1, 0, 32'h4, 0, 0);
        step();
        m1_valid = 0;
        set_m(0, 1, 0, 32'h8, 0, 0);
        repeat (3) step();
        check("hold_rdata", obs_rd, 32'hFF);
        repeat (4) step();
        m0_valid = 0;
        step();
        check("hold_cnt", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("hold_first", obs_q[0], 1);
            check("hold_second", obs_q[1], 0);
        end

        // memory never responds: timeout on 4th busy cycle, late ready ignored
        do_reset();
        mem_lat = 1000;
        set_m(0, 1, 0, 32'hC, 0, 0);
        start = step_n;
        step();
        m0_valid = 0;
        repeat (4) step();
        check("to_count", obs_q.size(), 1);
        check("to_err", 32'(obs_err), 32'd1);
        check("to_rdata", obs_rd, 32'h0);
        check("to_cycle", done_step - start, 4);
        spur_mode = 1;
        repeat (3) step();
        spur_mode = 0;
        check("to_late", obs_q.size(), 1);

        // reset mid-busy, then a fresh m1 request
        do_reset();
        mem_lat = 1000;
        set_m(1, 1, 0, 32'h4, 0, 0);
        step();
        s_ready = 1'b1;
        s_rdata = 32'hDEAD;
        #2;
        reset = 1'b0;
        #1;
        check("mid_s_valid", 32'(s_valid), 32'd0);
        check("mid_grant",   32'(grant), 32'd0);
        check("mid_m1_ready", 32'(m1_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        s_ready = 1'b0;
        mdl_reset();
        obs_q.delete();
        mem_lat = 0;
        step();
        m1_valid = 0;
        repeat (2) step();
        check("post_cnt", obs_q.size(), 1);
        if (obs_q.size() == 1) check("post_m1", obs_q[0], 1);
        check("post_rdata", obs_rd, 32'hFF);

        // randomized traffic
        spur_mode = 2;
        for (int c = 0; c < 500; c++) begin
            if (c % 25 == 0) mem_lat = $urandom_range(0, 5);
            for (int k = 0; k < 2; k++)
                set_m(k, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                      {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
